// File: rtl/xpe_dot_accum.sv
// Multi-lane XNOR-popcount dot-product accumulator with a two-stage pipeline and a held result register.
// Optional threshold output is enabled by defining XPE_DOT_THRESH_EN.
module xpe_dot_accum #(
   parameter int WORD_SIZE = 64,
   parameter int LANES     = 4,
   parameter int ACC_W     = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_last,
   input  logic [LANES*WORD_SIZE-1:0]   weight_in,
   input  logic [LANES*WORD_SIZE-1:0]   act_in,
   input  logic [LANES*WORD_SIZE-1:0]   mask_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [ACC_W:0]        out_dot,
   output logic [ACC_W-1:0]             out_match,
   output logic [ACC_W-1:0]             out_total,
`ifdef XPE_DOT_THRESH_EN
   input  logic signed [ACC_W:0]        thresh_in,
   output logic                         out_bit,
`endif
   output logic                         out_ovf
);

   localparam int BITS = LANES * WORD_SIZE;
   localparam int CW   = $clog2(BITS + 1);
   localparam int SW   = ((ACC_W > CW) ? ACC_W : CW) + 1;
   localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

   logic            live;
   logic            stall;
   logic            take;
   logic [BITS-1:0] match_bits;
   logic [CW-1:0]   bc_next;
   logic [CW-1:0]   vc_next;

   logic            s1_valid;
   logic            s1_last;
   logic [CW-1:0]   s1_bc;
   logic [CW-1:0]   s1_vc;

   logic [ACC_W-1:0]      match_acc;
   logic [ACC_W-1:0]      total_acc;
   logic                  ovf_acc;
   logic [SW-1:0]         m_sum;
   logic [SW-1:0]         t_sum;
   logic                  m_sat;
   logic                  t_sat;
   logic [ACC_W-1:0]      m_new;
   logic [ACC_W-1:0]      t_new;
   logic signed [ACC_W:0] dot_new;
   logic                  s2_fire;

   // live keeps in_ready low through reset and raises it on the first edge after release.
   assign stall    = out_valid & ~out_ready;
   assign in_ready = live & ~stall;
   assign take     = in_valid & in_ready;

   // Summing lane popcounts equals one popcount across the whole beat.
   assign match_bits = ~(weight_in ^ act_in) & mask_in;

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      bc_next = '0;
      vc_next = '0;
      for (int i = 0; i < BITS; i++) begin
         bc_next += CW'(match_bits[i]);
         vc_next += CW'(mask_in[i]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live     <= 1'b0;
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_bc    <= '0;
         s1_vc    <= '0;
      end else begin
         live <= 1'b1;
         if (clr) begin
            s1_valid <= 1'b0;
         end else if (take) begin
            s1_valid <= 1'b1;
            s1_last  <= in_last;
            s1_bc    <= bc_next;
            s1_vc    <= vc_next;
         end else if (!stall) begin
            s1_valid <= 1'b0;
         end
      end
   end

   assign m_sum   = SW'(match_acc) + SW'(s1_bc);
   assign t_sum   = SW'(total_acc) + SW'(s1_vc);
   assign m_sat   = m_sum > SW'(ACC_MAX);
   assign t_sat   = t_sum > SW'(ACC_MAX);
   assign m_new   = m_sat ? ACC_MAX : m_sum[ACC_W-1:0];
   assign t_new   = t_sat ? ACC_MAX : t_sum[ACC_W-1:0];
   // match never exceeds total, so 2*match - total always fits ACC_W+1 signed bits.
   assign dot_new = $signed({m_new, 1'b0}) - $signed({1'b0, t_new});
   assign s2_fire = s1_valid & ~stall & ~clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_acc <= '0;
         total_acc <= '0;
         ovf_acc   <= 1'b0;
         out_valid <= 1'b0;
         out_dot   <= '0;
         out_match <= '0;
         out_total <= '0;
         out_ovf   <= 1'b0;
`ifdef XPE_DOT_THRESH_EN
         out_bit   <= 1'b0;
`endif
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (clr) begin
            match_acc <= '0;
            total_acc <= '0;
            ovf_acc   <= 1'b0;
         end else if (s2_fire) begin
            if (s1_last) begin
               out_valid <= 1'b1;
               out_dot   <= dot_new;
               out_match <= m_new;
               out_total <= t_new;
               out_ovf   <= ovf_acc | m_sat | t_sat;
`ifdef XPE_DOT_THRESH_EN
               out_bit   <= (dot_new >= thresh_in);
`endif
               match_acc <= '0;
               total_acc <= '0;
               ovf_acc   <= 1'b0;
            end else begin
               match_acc <= m_new;
               total_acc <= t_new;
               ovf_acc   <= ovf_acc | m_sat | t_sat;
            end
         end
      end
   end

endmodule

// File: tb/tb_xpe_dot_accum.sv
// Scoreboard bench for xpe_dot_accum (WORD_SIZE=64, LANES=2, ACC_W=16) driven by directed vectors.
// Expected results are queued at each last beat and compared by an independent output monitor.
module tb_xpe_dot_accum;

   localparam int WS     = 64;
   localparam int LN     = 2;
   localparam int AW     = 16;
   localparam int BITS   = WS * LN;
   localparam int THRESH = 10;

   typedef struct {
      int dot;
      int match;
      int total;
      bit ovf;
      bit obit;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 clr = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic                 in_last = 1'b0;
   logic [BITS-1:0]      weight_in = '0;
   logic [BITS-1:0]      act_in = '0;
   logic [BITS-1:0]      mask_in = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic signed [AW:0]   out_dot;
   logic [AW-1:0]        out_match;
   logic [AW-1:0]        out_total;
   logic                 out_ovf;
`ifdef XPE_DOT_THRESH_EN
   logic signed [AW:0]   thresh_in = (AW+1)'(THRESH);
   logic                 out_bit;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   localparam logic [BITS-1:0] ONES = {BITS{1'b1}};
   localparam logic [BITS-1:0] PAT  = 128'h0123456789ABCDEF_FEDCBA9876543210;
   localparam logic [BITS-1:0] LOW8 = 128'hFF;
   localparam logic [BITS-1:0] LANE0 = 128'h0000000000000000_FFFFFFFFFFFFFFFF;

   xpe_dot_accum #(.WORD_SIZE(WS), .LANES(LN), .ACC_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .weight_in (weight_in),
      .act_in    (act_in),
      .mask_in   (mask_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dot   (out_dot),
      .out_match (out_match),
      .out_total (out_total),
`ifdef XPE_DOT_THRESH_EN
      .thresh_in (thresh_in),
      .out_bit   (out_bit),
`endif
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int m, input int t, input bit o);
      exp_t e;
      e.match = m;
      e.total = t;
      e.dot   = 2 * m - t;
      e.ovf   = o;
      e.obit  = (e.dot >= THRESH);
      sb.push_back(e);
   endtask

   // Holds the beat until accepted; returns 1 time unit after the accepting edge.
   task automatic send_beat(input logic [BITS-1:0] w, input logic [BITS-1:0] a,
                            input logic [BITS-1:0] m, input logic last);
      bit hs;
      hs = 1'b0;
      weight_in = w;
      act_in    = a;
      mask_in   = m;
      in_last   = last;
      in_valid  = 1'b1;
      for (int n = 0; n < 200 && !hs; n++) begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!hs) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stayed 0 at %0t", $time);
      end
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         done = (sb.size() == 0) && !out_valid;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain: %0d results still pending at %0t", sb.size(), $time);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares the presented result every cycle it is valid, pops on handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (!out_ready) check("stall_in_ready", int'(in_ready), 0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: dot %0d with empty scoreboard at %0t", out_dot, $time);
         end else begin
            check("out_dot", int'(out_dot), sb[0].dot);
            check("out_match", int'(out_match), sb[0].match);
            check("out_total", int'(out_total), sb[0].total);
            check("out_ovf", int'(out_ovf), int'(sb[0].ovf));
`ifdef XPE_DOT_THRESH_EN
            check("out_bit", int'(out_bit), int'(sb[0].obit));
`endif
            if (out_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_dot", int'(out_dot), 0);
      check("rst_out_ovf", int'(out_ovf), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_rst", int'(in_ready), 1);

      // 1: single full-match beat, latency of two cycles
      send_beat(PAT, PAT, ONES, 1'b1);
      push_exp(128, 128, 1'b0);
      check("lat_s1", int'(out_valid), 0);
      @(posedge clk);
      #1;
      check("lat_out", int'(out_valid), 1);
      drain();

      // 2: three beats, all mismatching
      for (int b = 0; b < 3; b++) send_beat(~PAT, PAT, ONES, b == 2);
      push_exp(0, 384, 1'b0);
      drain();

      // 3: partial mask, then an all-zero mask vector
      send_beat(PAT, PAT, LOW8, 1'b1);
      push_exp(8, 8, 1'b0);
      send_beat(PAT, ~PAT, '0, 1'b1);
      push_exp(0, 0, 1'b0);
      drain();

      // 4: back-to-back vectors with a 5-cycle output stall
      out_ready = 1'b0;
      fork
         begin
            send_beat(ONES, ONES, ONES, 1'b1);
            push_exp(128, 128, 1'b0);
            send_beat(~PAT, PAT, ONES, 1'b0);
            send_beat(PAT, PAT, LANE0, 1'b1);
            push_exp(64, 192, 1'b0);
         end
         begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 50 && !seen; n++) begin
               @(negedge clk);
               seen = out_valid;
            end
            if (!seen) begin
               checks++;
               errors++;
               $display("FAIL stall_wait: out_valid never rose at %0t", $time);
            end
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // 5: accumulator saturation over 520 full-match beats, then ovf clears
      for (int b = 0; b < 520; b++) send_beat(ONES, ONES, ONES, b == 519);
      push_exp(65535, 65535, 1'b1);
      send_beat(ONES, ONES, ONES, 1'b1);
      push_exp(128, 128, 1'b0);
      drain();

      // 6a: reset mid-vector while a result is held
      out_ready = 1'b0;
      send_beat(ONES, ONES, ONES, 1'b1);
      push_exp(128, 128, 1'b0);
      send_beat(ONES, ONES, ONES, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      sb.delete();
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_dot", int'(out_dot), 0);
      check("mid_rst_match", int'(out_match), 0);
      check("mid_rst_total", int'(out_total), 0);
      check("mid_rst_ovf", int'(out_ovf), 0);
      check("mid_rst_ready", int'(in_ready), 0);
      out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release_ready0", int'(in_ready), 0);
      @(posedge clk);
      #1;
      check("release_ready1", int'(in_ready), 1);
      send_beat(PAT, PAT, LOW8, 1'b1);
      push_exp(8, 8, 1'b0);
      drain();

      // 6b: clr mid-vector discards the partial sums
      send_beat(ONES, ONES, ONES, 1'b0);
      send_beat(ONES, ONES, ONES, 1'b0);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      send_beat(PAT, PAT, LOW8, 1'b1);
      push_exp(8, 8, 1'b0);
      drain();

      // 6c: clr wins over a last beat accepted in the same cycle
      clr = 1'b1;
      send_beat(ONES, ONES, ONES, 1'b1);
      clr = 1'b0;
      send_beat(PAT, ~PAT, LANE0, 1'b1);
      push_exp(0, 64, 1'b0);
      drain();

      // 7: threshold crossing pair (+8 then +128)
      send_beat(PAT, PAT, LOW8, 1'b1);
      push_exp(8, 8, 1'b0);
      send_beat(PAT, PAT, ONES, 1'b1);
      push_exp(128, 128, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
